// File: rtl/packet_tagger.sv
// packet_tagger: credit-limited reorder-tag issue, forking each beat to the circular buffer and the core dispatch path
module packet_tagger #(
  parameter int TAG_WIDTH = 6,
  parameter int CIRCULAR_BUFFER_SIZE = 50,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_TDATA,
  input  logic [DATA_WIDTH/8-1:0] s_TKEEP,
  input  logic                    s_TLAST,
  input  logic                    s_TVALID,
  output logic                    s_TREADY,
  output logic [DATA_WIDTH-1:0]   buf_TDATA,
  output logic [DATA_WIDTH/8-1:0] buf_TKEEP,
  output logic                    buf_TLAST,
  output logic [TAG_WIDTH-1:0]    buf_reorder_tag,
  output logic                    buf_TVALID,
  input  logic                    buf_TREADY,
  output logic [DATA_WIDTH-1:0]   core_TDATA,
  output logic [DATA_WIDTH/8-1:0] core_TKEEP,
  output logic                    core_TLAST,
  output logic [TAG_WIDTH-1:0]    core_reorder_tag,
  output logic                    core_TVALID,
  input  logic                    core_TREADY,
  input  logic                    release_valid,
  output logic                    alloc_valid,
  output logic [TAG_WIDTH-1:0]    alloc_tag,
  output logic [TAG_WIDTH:0]      outstanding
);
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH/8-1:0] keep;
  logic last, buf_pend, core_pend, sop, slot_full, drain, accept, rel;
  logic [TAG_WIDTH-1:0] tag, cur_tag;
  assign slot_full = buf_pend || core_pend;
  assign drain = slot_full && (!buf_pend || buf_TREADY) && (!core_pend || core_TREADY);
  // credit gates only the first beat, so a started packet never stalls mid-way
  assign s_TREADY = !rst && (!slot_full || drain) &&
                    (!sop || outstanding < (TAG_WIDTH+1)'(CIRCULAR_BUFFER_SIZE));
  assign accept = s_TVALID && s_TREADY;
  assign alloc_valid = accept && sop;
  assign alloc_tag = cur_tag;
  assign rel = release_valid && outstanding != '0;
  assign buf_TDATA = data;
  assign buf_TKEEP = keep;
  assign buf_TLAST = last;
  assign buf_reorder_tag = tag;
  assign buf_TVALID = buf_pend;
  assign core_TDATA = data;
  assign core_TKEEP = keep;
  assign core_TLAST = last;
  assign core_reorder_tag = tag;
  assign core_TVALID = core_pend;
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_pend <= 1'b0;
      core_pend <= 1'b0;
      sop <= 1'b1;
      cur_tag <= '0;
      outstanding <= '0;
    end else begin
      buf_pend <= accept || (buf_pend && !buf_TREADY);
      core_pend <= accept || (core_pend && !core_TREADY);
      if (accept) begin
        data <= s_TDATA;
        keep <= s_TKEEP;
        last <= s_TLAST;
        tag <= cur_tag;
        sop <= s_TLAST;
        if (s_TLAST)
          cur_tag <= cur_tag == TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1) ? '0 : cur_tag + 1'b1;
      end
      outstanding <= outstanding + (TAG_WIDTH+1)'(alloc_valid) - (TAG_WIDTH+1)'(rel);
    end
  end
endmodule

// File: tb/tb_packet_tagger.sv
// tb_packet_tagger: scoreboard bench for packet_tagger with an independent tag/credit model
module tb_packet_tagger;
  localparam int TW = 6, SZ = 50, DW = 64;
  logic clk = 0, rst = 1;
  logic [DW-1:0] s_TDATA = '0;
  logic [DW/8-1:0] s_TKEEP = '0;
  logic s_TLAST = 0, s_TVALID = 0, s_TREADY;
  logic [DW-1:0] buf_TDATA, core_TDATA;
  logic [DW/8-1:0] buf_TKEEP, core_TKEEP;
  logic buf_TLAST, buf_TVALID, core_TLAST, core_TVALID;
  logic buf_TREADY = 1, core_TREADY = 1, release_valid = 0, alloc_valid;
  logic [TW-1:0] buf_reorder_tag, core_reorder_tag, alloc_tag;
  logic [TW:0] outstanding;
  int vectors = 0, miscompares = 0;

  packet_tagger #(.TAG_WIDTH(TW), .CIRCULAR_BUFFER_SIZE(SZ), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .s_TDATA(s_TDATA), .s_TKEEP(s_TKEEP), .s_TLAST(s_TLAST),
    .s_TVALID(s_TVALID), .s_TREADY(s_TREADY), .buf_TDATA(buf_TDATA), .buf_TKEEP(buf_TKEEP),
    .buf_TLAST(buf_TLAST), .buf_reorder_tag(buf_reorder_tag), .buf_TVALID(buf_TVALID),
    .buf_TREADY(buf_TREADY), .core_TDATA(core_TDATA), .core_TKEEP(core_TKEEP),
    .core_TLAST(core_TLAST), .core_reorder_tag(core_reorder_tag), .core_TVALID(core_TVALID),
    .core_TREADY(core_TREADY), .release_valid(release_valid), .alloc_valid(alloc_valid),
    .alloc_tag(alloc_tag), .outstanding(outstanding));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  typedef logic [78:0] beat_t;
  beat_t bq[$], cq[$];
  logic [TW-1:0] m_tag = '0;
  logic m_sop = 1;
  int m_out = 0;
  logic pb_v = 0, pb_r = 0, pc_v = 0, pc_r = 0;
  beat_t pb, pc;

  always @(negedge clk) begin
    beat_t bo, co;
    logic acc;
    bo = {buf_TLAST, buf_TKEEP, buf_TDATA, buf_reorder_tag};
    co = {core_TLAST, core_TKEEP, core_TDATA, core_reorder_tag};
    if (rst) begin
      bq.delete(); cq.delete();
      m_tag = '0; m_sop = 1; m_out = 0; pb_v = 0; pc_v = 0;
    end else begin
      acc = s_TVALID && s_TREADY;
      chk("outstanding", outstanding, m_out);
      chk("alloc_valid", alloc_valid, acc && m_sop);
      if (m_sop && m_out >= SZ) chk("credit_stall", s_TREADY, 0);
      if (pb_v && !pb_r) chk("buf_stable", {buf_TVALID, bo}, {1'b1, pb});
      if (pc_v && !pc_r) chk("core_stable", {core_TVALID, co}, {1'b1, pc});
      if (buf_TVALID && buf_TREADY) begin
        if (bq.size() == 0) chk("buf_extra_beat", 1, 0);
        else chk("buf_beat", bo, bq.pop_front());
      end
      if (core_TVALID && core_TREADY) begin
        if (cq.size() == 0) chk("core_extra_beat", 1, 0);
        else chk("core_beat", co, cq.pop_front());
      end
      if (acc) begin
        bq.push_back({s_TLAST, s_TKEEP, s_TDATA, m_tag});
        cq.push_back({s_TLAST, s_TKEEP, s_TDATA, m_tag});
        if (m_sop) chk("alloc_tag", alloc_tag, m_tag);
        m_out += (m_sop ? 1 : 0) - ((release_valid && m_out > 0) ? 1 : 0);
        if (s_TLAST) m_tag = (m_tag == TW'(SZ - 1)) ? '0 : m_tag + 1'b1;
        m_sop = s_TLAST;
      end else if (release_valid && m_out > 0) m_out--;
      pb_v = buf_TVALID; pb_r = buf_TREADY; pb = bo;
      pc_v = core_TVALID; pc_r = core_TREADY; pc = co;
    end
  end

  task automatic beat(input logic last, output int waits);
    logic hs;
    s_TVALID = 1; s_TDATA = {$urandom, $urandom}; s_TKEEP = 8'($urandom); s_TLAST = last;
    waits = 0;
    forever begin
      @(negedge clk); hs = s_TREADY;
      @(posedge clk); #1;
      if (hs) break;
      waits++;
      if (waits > 200) begin chk("handshake_timeout", 1, 0); break; end
    end
    s_TVALID = 0;
    chk("valid_after_accept", {buf_TVALID, core_TVALID}, 2'b11);
  endtask

  task automatic pkt(input int n);
    int w;
    for (int i = 0; i < n; i++) beat(i == n - 1, w);
  endtask

  task automatic do_reset();
    rst = 1; @(posedge clk); #1; rst = 0;
  endtask

  task automatic pulse_release();
    release_valid = 1; @(posedge clk); #1; release_valid = 0;
  endtask

  initial begin
    int w;
    s_TVALID = 1;
    @(posedge clk); #1;
    @(negedge clk); chk("rst_tready", s_TREADY, 0);
    @(posedge clk); #1; rst = 0; s_TVALID = 0;
    chk("rst_state", {buf_TVALID, core_TVALID, alloc_valid, outstanding}, 0);
    // three 4-beat packets, both sides always ready
    for (int p = 0; p < 3; p++) pkt(4);
    @(posedge clk); #1;
    chk("three_pkts_out", outstanding, 3);
    // 50 single-beat packets fill the credit, then release frees one slot a cycle later
    do_reset();
    pulse_release();
    chk("no_underflow", outstanding, 0);
    for (int p = 0; p < SZ; p++) pkt(1);
    s_TVALID = 1; s_TLAST = 1; s_TDATA = 64'hdead_beef_0051_0051;
    repeat (3) begin @(negedge clk); chk("full_stall", s_TREADY, 0); @(posedge clk); #1; end
    chk("full_out", outstanding, SZ);
    release_valid = 1;
    @(negedge clk); chk("release_same_cycle", s_TREADY, 0);
    @(posedge clk); #1; release_valid = 0;
    @(negedge clk); chk("release_next_cycle", s_TREADY, 1);
    @(posedge clk); #1; s_TVALID = 0;
    // core side stalls for 3 cycles while buffer side accepts
    do_reset();
    core_TREADY = 0;
    beat(1, w);
    s_TVALID = 1; s_TLAST = 1; s_TDATA = 64'h0123_4567_89ab_cdef;
    repeat (3) begin @(negedge clk); chk("core_stall_tready", s_TREADY, 0); @(posedge clk); #1; end
    core_TREADY = 1;
    beat(1, w);
    // release coincident with a first-beat acceptance at outstanding=10
    for (int p = 0; p < 8; p++) pkt(1);
    @(posedge clk); #1;
    chk("pre_coincident", outstanding, 10);
    release_valid = 1; beat(1, w); release_valid = 0;
    chk("coincident_out", outstanding, 10);
    // credit runs out on the first beat of a 6-beat packet
    for (int p = 0; p < 39; p++) pkt(1);
    beat(0, w);
    for (int i = 1; i < 6; i++) begin beat(i == 5, w); chk("mid_pkt_no_stall", w, 0); end
    chk("credit_full", outstanding, SZ);
    // reset on beat 2 of a 5-beat packet
    do_reset();
    beat(0, w); beat(0, w);
    s_TVALID = 1; s_TLAST = 0; rst = 1;
    @(negedge clk); chk("mid_rst_tready", s_TREADY, 0);
    @(posedge clk); #1; rst = 0; s_TVALID = 0;
    chk("post_rst", {buf_TVALID, core_TVALID, outstanding}, 0);
    beat(1, w);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_out", outstanding, 1);
    chk("buf_q_empty", bq.size(), 0);
    chk("core_q_empty", cq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
